// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
// Module : mips_multicycle_ctrl
// Brief  : Main control FSM and ALU decoder for a multicycle MIPS core.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    localparam logic [3:0] c_S_FETCH   = 4'd0;
    localparam logic [3:0] c_S_DECODE  = 4'd1;
    localparam logic [3:0] c_S_MEMADR  = 4'd2;
    localparam logic [3:0] c_S_MEMRD   = 4'd3;
    localparam logic [3:0] c_S_MEMWB   = 4'd4;
    localparam logic [3:0] c_S_MEMWR   = 4'd5;
    localparam logic [3:0] c_S_RTYPEEX = 4'd6;
    localparam logic [3:0] c_S_RTYPEWB = 4'd7;
    localparam logic [3:0] c_S_BEQEX   = 4'd8;
    localparam logic [3:0] c_S_ADDIEX  = 4'd9;
    localparam logic [3:0] c_S_ADDIWB  = 4'd10;
    localparam logic [3:0] c_S_JEX     = 4'd11;

    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [3:0] c_WAIT = MEM_WAIT[3:0];

    logic [3:0] r_state;
    logic [3:0] r_wait;
    logic [3:0] w_next;
    logic       w_memstate;
    logic       w_last;
    logic       w_illegal;
    logic       w_pcwrite;
    logic       w_branch;
    logic [1:0] w_aluop;
    logic       w_irwrite;
    logic       w_memwrite;
    logic       w_regwrite;

    assign w_memstate = (r_state == c_S_FETCH) || (r_state == c_S_MEMRD) ||
                        (r_state == c_S_MEMWR);
    // Non-memory states always complete in one cycle.
    assign w_last     = !w_memstate || (r_wait == c_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_FETCH;
            r_wait  <= 4'd0;
        end else if (w_last) begin
            r_state <= w_next;
            r_wait  <= 4'd0;
        end else begin
            r_wait  <= r_wait + 4'd1;
        end
    end

    always_comb begin
        w_next    = c_S_FETCH;
        w_illegal = 1'b0;
        case (r_state)
            c_S_FETCH:   w_next = c_S_DECODE;
            c_S_DECODE: begin
                case (op)
                    c_OP_LW, c_OP_SW: w_next = c_S_MEMADR;
                    c_OP_RTYPE:       w_next = c_S_RTYPEEX;
                    c_OP_BEQ:         w_next = c_S_BEQEX;
                    c_OP_ADDI:        w_next = c_S_ADDIEX;
                    c_OP_J:           w_next = c_S_JEX;
                    default: begin
                        w_next    = c_S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            c_S_MEMADR:  w_next = (op == c_OP_SW) ? c_S_MEMWR : c_S_MEMRD;
            c_S_MEMRD:   w_next = c_S_MEMWB;
            c_S_RTYPEEX: w_next = c_S_RTYPEWB;
            c_S_ADDIEX:  w_next = c_S_ADDIWB;
            default:     w_next = c_S_FETCH;
        endcase
    end

    always_comb begin
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_aluop    = 2'b00;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        case (r_state)
            c_S_FETCH: begin
                w_irwrite = w_last;
                w_pcwrite = w_last;
                alusrcb   = 2'b01;
            end
            c_S_DECODE:  alusrcb = 2'b11;
            c_S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            c_S_MEMRD:   iord = 1'b1;
            c_S_MEMWR: begin
                iord       = 1'b1;
                w_memwrite = w_last;
            end
            c_S_MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
            end
            c_S_RTYPEEX: begin
                alusrca = 1'b1;
                w_aluop = 2'b10;
            end
            c_S_RTYPEWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
            end
            c_S_BEQEX: begin
                alusrca  = 1'b1;
                w_aluop  = 2'b01;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
            end
            c_S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            c_S_ADDIWB:  w_regwrite = 1'b1;
            c_S_JEX: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alucontrol = 3'b010;
        case (w_aluop)
            2'b00: alucontrol = 3'b010;
            2'b01: alucontrol = 3'b110;
            default: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
        endcase
    end

    // Strobes are suppressed while reset is asserted so an abandoned instruction writes nothing.
    assign pcen       = (w_pcwrite | (w_branch & zero)) & ~reset;
    assign irwrite    = w_irwrite  & ~reset;
    assign memwrite   = w_memwrite & ~reset;
    assign regwrite   = w_regwrite & ~reset;
    assign illegal_op = w_illegal  & ~reset;
    assign state_dbg  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// ============================================================================
// Module : tb_mips_multicycle_ctrl
// Brief  : Self-checking bench for mips_multicycle_ctrl (MEM_WAIT 0 and 2).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;

    logic       d0_pcen, d0_iord, d0_memwrite, d0_irwrite, d0_regdst, d0_memtoreg;
    logic       d0_regwrite, d0_alusrca, d0_illegal;
    logic [1:0] d0_alusrcb, d0_pcsrc;
    logic [2:0] d0_alu;
    logic [3:0] d0_state;
    logic       d2_pcen, d2_iord, d2_memwrite, d2_irwrite, d2_regdst, d2_memtoreg;
    logic       d2_regwrite, d2_alusrca, d2_illegal;
    logic [1:0] d2_alusrcb, d2_pcsrc;
    logic [2:0] d2_alu;
    logic [3:0] d2_state;

    mips_multicycle_ctrl #(.MEM_WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(d0_pcen), .iord(d0_iord), .memwrite(d0_memwrite), .irwrite(d0_irwrite),
        .regdst(d0_regdst), .memtoreg(d0_memtoreg), .regwrite(d0_regwrite),
        .alusrca(d0_alusrca), .alusrcb(d0_alusrcb), .pcsrc(d0_pcsrc),
        .alucontrol(d0_alu), .illegal_op(d0_illegal), .state_dbg(d0_state)
    );

    mips_multicycle_ctrl #(.MEM_WAIT(2)) u_dut2 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(d2_pcen), .iord(d2_iord), .memwrite(d2_memwrite), .irwrite(d2_irwrite),
        .regdst(d2_regdst), .memtoreg(d2_memtoreg), .regwrite(d2_regwrite),
        .alusrca(d2_alusrca), .alusrcb(d2_alusrcb), .pcsrc(d2_pcsrc),
        .alucontrol(d2_alu), .illegal_op(d2_illegal), .state_dbg(d2_state)
    );

    always #5 clk = ~clk;

    // Bit order: pcen iord memwrite irwrite regdst memtoreg regwrite alusrca alusrcb pcsrc alu illegal
    logic [15:0] w_act0, w_act2;
    assign w_act0 = {d0_pcen, d0_iord, d0_memwrite, d0_irwrite, d0_regdst, d0_memtoreg,
                     d0_regwrite, d0_alusrca, d0_alusrcb, d0_pcsrc, d0_alu, d0_illegal};
    assign w_act2 = {d2_pcen, d2_iord, d2_memwrite, d2_irwrite, d2_regdst, d2_memtoreg,
                     d2_regwrite, d2_alusrca, d2_alusrcb, d2_pcsrc, d2_alu, d2_illegal};

    bit     sel = 1'b0;
    int     n_vec = 0;
    int     n_bad = 0;
    int     q_path[$];

    function automatic logic [15:0] act();
        return sel ? w_act2 : w_act0;
    endfunction

    function automatic logic [3:0] cur_state();
        return sel ? d2_state : d0_state;
    endfunction

    task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    function automatic logic [2:0] alu_of(input int aluop, input logic [5:0] f);
        if (aluop == 0) return 3'b010;
        if (aluop == 1) return 3'b110;
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic bit legal(input logic [5:0] o);
        return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
               (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
    endfunction

    // Expected outputs from the per-state table; 'last' marks the final cycle of a state.
    function automatic logic [15:0] exp_out(input int st, input bit last, input logic [5:0] o,
                                            input logic [5:0] f, input logic z);
        logic [15:0] e;
        int          aluop;
        e     = '0;
        aluop = 0;
        case (st)
            0:  begin e[15] = last; e[12] = last; e[7:6] = 2'b01; end
            1:  begin e[7:6] = 2'b11; e[0] = !legal(o); end
            2:  begin e[8] = 1'b1; e[7:6] = 2'b10; end
            3:  e[14] = 1'b1;
            4:  begin e[10] = 1'b1; e[9] = 1'b1; end
            5:  begin e[14] = 1'b1; e[13] = last; end
            6:  begin e[8] = 1'b1; aluop = 2; end
            7:  begin e[11] = 1'b1; e[9] = 1'b1; end
            8:  begin e[8] = 1'b1; aluop = 1; e[5:4] = 2'b01; e[15] = z; end
            9:  begin e[8] = 1'b1; e[7:6] = 2'b10; end
            10: e[9] = 1'b1;
            11: begin e[5:4] = 2'b10; e[15] = 1'b1; end
            default: ;
        endcase
        e[3:1] = alu_of(aluop, f);
        return e;
    endfunction

    task automatic build_path(input logic [5:0] o);
        q_path = {0, 1};
        case (o)
            6'b100011: q_path = {q_path, 2, 3, 4};
            6'b101011: q_path = {q_path, 2, 5};
            6'b000000: q_path = {q_path, 6, 7};
            6'b000100: q_path.push_back(8);
            6'b001000: q_path = {q_path, 9, 10};
            6'b000010: q_path.push_back(11);
            default: ;
        endcase
    endtask

    // Called at a negedge; leaves time at the negedge that starts the next instruction.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
        int mw;
        int dur;
        op    = o;
        funct = f;
        zero  = z;
        mw    = sel ? 2 : 0;
        build_path(o);
        foreach (q_path[i]) begin
            dur = (q_path[i] == 0 || q_path[i] == 3 || q_path[i] == 5) ? mw + 1 : 1;
            for (int c = 0; c < dur; c++) begin
                #1;
                chk("state", {12'd0, cur_state()}, 16'(q_path[i]));
                chk("outputs", act(), exp_out(q_path[i], c == dur - 1, o, f, z));
                @(negedge clk);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_state", {12'd0, cur_state()}, 16'd0);
        chk("reset_irwrite", {15'd0, sel ? d2_irwrite : d0_irwrite}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         cyc;
        logic [2:0] alu2;
        logic       pcen2;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [2:0] a2;
        logic       p2;
        logic       saw_mw;
        int         k;
        bit         done;
        logic [5:0] ops[6];

        tbl[0]  = '{6'b100011, 6'b000000, 1'b0, 5, 3'b010, 1'b0};
        tbl[1]  = '{6'b101011, 6'b000000, 1'b0, 4, 3'b010, 1'b0};
        tbl[2]  = '{6'b000000, 6'b101010, 1'b0, 4, 3'b111, 1'b0};
        tbl[3]  = '{6'b000000, 6'b100000, 1'b0, 4, 3'b010, 1'b0};
        tbl[4]  = '{6'b000000, 6'b100010, 1'b1, 4, 3'b110, 1'b0};
        tbl[5]  = '{6'b000000, 6'b100100, 1'b0, 4, 3'b000, 1'b0};
        tbl[6]  = '{6'b000000, 6'b100101, 1'b0, 4, 3'b001, 1'b0};
        tbl[7]  = '{6'b000000, 6'b000111, 1'b0, 4, 3'b010, 1'b0};
        tbl[8]  = '{6'b000100, 6'b101010, 1'b1, 3, 3'b110, 1'b1};
        tbl[9]  = '{6'b000100, 6'b101010, 1'b0, 3, 3'b110, 1'b0};
        tbl[10] = '{6'b001000, 6'b100010, 1'b0, 4, 3'b010, 1'b0};
        tbl[11] = '{6'b000010, 6'b000000, 1'b0, 3, 3'b010, 1'b1};
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

        // Latency and execute-cycle decode, one instruction per reset, MEM_WAIT=0.
        sel = 1'b0;
        foreach (tbl[i]) begin
            do_reset();
            op    = tbl[i].op;
            funct = tbl[i].funct;
            zero  = tbl[i].zero;
            k     = 0;
            done  = 1'b0;
            a2    = 3'bxxx;
            p2    = 1'bx;
            while (!done) begin
                #1;
                if (k == 2) begin
                    a2 = d0_alu;
                    p2 = d0_pcen;
                end
                if ((k > 0 && d0_state == 4'd0) || k >= 20) done = 1'b1;
                else begin
                    @(negedge clk);
                    k++;
                end
            end
            chk("tbl_cycles", 16'(k), 16'(tbl[i].cyc));
            chk("tbl_alu", {13'd0, a2}, {13'd0, tbl[i].alu2});
            chk("tbl_pcen", {15'd0, p2}, {15'd0, tbl[i].pcen2});
        end

        // Hand sequences: lw at MEM_WAIT=0, sw and illegal op at MEM_WAIT=2.
        sel = 1'b0;
        do_reset();
        run_instr(6'b100011, 6'b000000, 1'b0);
        run_instr(6'b111111, 6'b000000, 1'b0);
        sel = 1'b1;
        do_reset();
        run_instr(6'b101011, 6'b000000, 1'b0);
        run_instr(6'b111111, 6'b100000, 1'b0);
        run_instr(6'b000100, 6'b000000, 1'b1);

        // Reset in the second MEMWR cycle must abandon the store.
        sel = 1'b1;
        do_reset();
        op     = 6'b101011;
        zero   = 1'b0;
        saw_mw = 1'b0;
        k      = 0;
        #1;
        while (d2_state != 4'd5 && k < 20) begin
            saw_mw |= d2_memwrite;
            @(negedge clk);
            #1;
            k++;
        end
        chk("reach_memwr", {12'd0, d2_state}, 16'd5);
        saw_mw |= d2_memwrite;
        @(negedge clk);
        reset = 1'b1;
        #1;
        saw_mw |= d2_memwrite;
        chk("memwr_2nd_state", {12'd0, d2_state}, 16'd5);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            saw_mw |= d2_memwrite;
            chk("post_reset_state", {12'd0, d2_state}, 16'd0);
            chk("post_reset_irwrite", {15'd0, d2_irwrite}, {15'd0, (c == 2)});
            @(negedge clk);
        end
        chk("no_memwrite", {15'd0, saw_mw}, 16'd0);

        // Randomized instruction streams on both wait settings.
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            do_reset();
            for (int n = 0; n < 40; n++) begin
                logic [5:0] o;
                logic [5:0] f;
                int         r;
                r = $urandom_range(0, 6);
                o = (r == 6) ? 6'($urandom) : ops[r];
                r = $urandom_range(0, 9);
                case (r)
                    0: f = 6'b100000;
                    1: f = 6'b100010;
                    2: f = 6'b100100;
                    3: f = 6'b100101;
                    4: f = 6'b101010;
                    default: f = 6'($urandom);
                endcase
                run_instr(o, f, 1'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
